dcache_data_arbiter: RTL and testbench



---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_data_arbiter_if.sv | 48 ++++
 rtl/dcache_refill_beat_mux.sv | 24 ++
 rtl/dcache_data_arbiter.sv | 157 +++++++++++++++
 tb/tb_dcache_data_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the D-cache data store arbiter.
// Optional feature macro used by the arbiter: DCACHE_ARB_STARVE_GUARD_EN.
package dcache_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_REFILL = 1'b1
  } arb_state_e;

  localparam int DCACHE_DATA_WIDTH = 128;
  localparam int DCACHE_BEAT_WIDTH = 64;

  // A single-beat line still needs a one-bit counter so the port never collapses to zero width.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int REFILL_BEATS = DCACHE_DATA_WIDTH / DCACHE_BEAT_WIDTH;
  localparam int BEAT_CNT_W   = beat_cnt_width(REFILL_BEATS);

endpackage

// File: rtl/dcache_data_arbiter_if.sv
// Requester-side bundle of the data store arbiter: refill burst, store and load channels.
// Signal suffixes are from the arbiter's point of view; the arbiter uses the slave modport.
interface dcache_data_arbiter_if #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 256,
  parameter int BEAT_WIDTH = 64
);
  localparam int IdxW     = $clog2(NUM_WORDS);
  localparam int NumBytes = DATA_WIDTH / 8;

  logic                  refill_start_i;
  logic [IdxW-1:0]       refill_idx_i;
  logic                  refill_beat_valid_i;
  logic [BEAT_WIDTH-1:0] refill_beat_i;
  logic                  refill_ready_o;
  logic                  refill_done_o;

  logic                  st_req_i;
  logic [IdxW-1:0]       st_idx_i;
  logic [NumBytes-1:0]   st_be_i;
  logic [DATA_WIDTH-1:0] st_wdata_i;
  logic                  st_gnt_o;

  logic                  ld_req_i;
  logic [IdxW-1:0]       ld_idx_i;
  logic                  ld_gnt_o;
  logic                  ld_rvalid_o;
  logic [DATA_WIDTH-1:0] ld_rdata_o;

  modport master (
    output refill_start_i, refill_idx_i, refill_beat_valid_i, refill_beat_i,
    input  refill_ready_o, refill_done_o,
    output st_req_i, st_idx_i, st_be_i, st_wdata_i,
    input  st_gnt_o,
    output ld_req_i, ld_idx_i,
    input  ld_gnt_o, ld_rvalid_o, ld_rdata_o
  );

  modport slave (
    input  refill_start_i, refill_idx_i, refill_beat_valid_i, refill_beat_i,
    output refill_ready_o, refill_done_o,
    input  st_req_i, st_idx_i, st_be_i, st_wdata_i,
    output st_gnt_o,
    input  ld_req_i, ld_idx_i,
    output ld_gnt_o, ld_rvalid_o, ld_rdata_o
  );

endinterface

// File: rtl/dcache_refill_beat_mux.sv
// Places one refill beat into its slice of a cache line: byte enables select the slice,
// write data carries the beat replicated across every slice.
module dcache_refill_beat_mux
  import dcache_pkg::*;
#(
  parameter int  DATA_WIDTH = 128,
  parameter int  BEAT_WIDTH = 64,
  localparam int CntW       = beat_cnt_width(DATA_WIDTH / BEAT_WIDTH)
) (
  input  logic [CntW-1:0]         beat_idx_i,
  input  logic [BEAT_WIDTH-1:0]   beat_i,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [DATA_WIDTH-1:0]   wdata_o
);

  localparam int Beats     = DATA_WIDTH / BEAT_WIDTH;
  localparam int BeatBytes = BEAT_WIDTH / 8;

  for (genvar k = 0; k < Beats; k++) begin : g_beat
    assign be_o[k*BeatBytes +: BeatBytes]     = {BeatBytes{beat_idx_i == CntW'(k)}};
    assign wdata_o[k*BEAT_WIDTH +: BEAT_WIDTH] = beat_i;
  end

endmodule

// File: rtl/dcache_data_arbiter.sv
// Sequencer/arbiter for the single-port D-cache data store: refill burst > store > load.
// Define DCACHE_ARB_STARVE_GUARD_EN to let a load that lost MAX_WAIT cycles in a row beat stores.
module dcache_data_arbiter
  import dcache_pkg::*;
#(
  parameter int  DATA_WIDTH = 128,
  parameter int  NUM_WORDS  = 256,
  parameter int  BEAT_WIDTH = 64,
  parameter int  MAX_WAIT   = 8,
  localparam int IdxW       = $clog2(NUM_WORDS),
  localparam int NumBytes   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_data_arbiter_if.slave  req_if,
  output logic                  ds_en_o,
  output logic                  ds_we_o,
  output logic [NumBytes-1:0]   ds_be_o,
  output logic [IdxW-1:0]       ds_addr_o,
  output logic [DATA_WIDTH-1:0] ds_wdata_o,
  input  logic [DATA_WIDTH-1:0] ds_rdata_i
);

  localparam int Beats = DATA_WIDTH / BEAT_WIDTH;
  localparam int CntW  = beat_cnt_width(Beats);

  if (MAX_WAIT < 1 || (DATA_WIDTH % BEAT_WIDTH) != 0) begin : g_param_err
    $error("dcache_data_arbiter: MAX_WAIT must be >= 1 and DATA_WIDTH a multiple of BEAT_WIDTH");
  end

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       beatCnt_q, beatCnt_d;
  logic [IdxW-1:0]       refillIdx_q, refillIdx_d;
  logic                  ldRvalid_q;
  logic                  stGnt, ldGnt, refillDone, starveHit;
  logic [NumBytes-1:0]   beatBe;
  logic [DATA_WIDTH-1:0] beatWdata;

  dcache_refill_beat_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_beat_mux (
    .beat_idx_i (beatCnt_q),
    .beat_i     (req_if.refill_beat_i),
    .be_o       (beatBe),
    .wdata_o    (beatWdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      beatCnt_q   <= '0;
      refillIdx_q <= '0;
      ldRvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beatCnt_q   <= beatCnt_d;
      refillIdx_q <= refillIdx_d;
      ldRvalid_q  <= ldGnt;
    end
  end

  // Grants are gated by reset so nothing reaches the SRAM while the block is held in reset.
  always_comb begin
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    refillIdx_d = refillIdx_q;
    stGnt       = 1'b0;
    ldGnt       = 1'b0;
    refillDone  = 1'b0;
    ds_en_o     = 1'b0;
    ds_we_o     = 1'b0;
    ds_be_o     = '0;
    ds_addr_o   = '0;
    ds_wdata_o  = '0;
    if (!rst_i) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (req_if.refill_start_i) begin
            refillIdx_d = req_if.refill_idx_i;
            beatCnt_d   = '0;
            state_d     = ARB_REFILL;
          end else if (req_if.ld_req_i && starveHit) begin
            ldGnt = 1'b1;
          end else if (req_if.st_req_i) begin
            stGnt = 1'b1;
          end else if (req_if.ld_req_i) begin
            ldGnt = 1'b1;
          end
          if (stGnt) begin
            ds_en_o    = 1'b1;
            ds_we_o    = 1'b1;
            ds_be_o    = req_if.st_be_i;
            ds_addr_o  = req_if.st_idx_i;
            ds_wdata_o = req_if.st_wdata_i;
          end else if (ldGnt) begin
            ds_en_o   = 1'b1;
            ds_addr_o = req_if.ld_idx_i;
          end
        end
        ARB_REFILL: begin
          if (req_if.refill_beat_valid_i) begin
            ds_en_o    = 1'b1;
            ds_we_o    = 1'b1;
            ds_be_o    = beatBe;
            ds_addr_o  = refillIdx_q;
            ds_wdata_o = beatWdata;
            if (beatCnt_q == CntW'(Beats - 1)) begin
              refillDone = 1'b1;
              beatCnt_d  = '0;
              state_d    = ARB_IDLE;
            end else begin
              beatCnt_d = beatCnt_q + CntW'(1);
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int StarveW = $clog2(MAX_WAIT + 1);

  logic [StarveW-1:0] starveCnt_q, starveCnt_d;

  // Only cycles lost while arbitration is open count; a refill burst is not a loss.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!req_if.ld_req_i || ldGnt) begin
      starveCnt_d = '0;
    end else if (state_q == ARB_IDLE && starveCnt_q != StarveW'(MAX_WAIT)) begin
      starveCnt_d = starveCnt_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

  assign starveHit = (starveCnt_q == StarveW'(MAX_WAIT));
`else
  assign starveHit = 1'b0;
`endif

  assign req_if.refill_ready_o = (state_q == ARB_IDLE) || (state_q == ARB_REFILL);
  assign req_if.refill_done_o  = refillDone;
  assign req_if.st_gnt_o       = stGnt;
  assign req_if.ld_gnt_o       = ldGnt;
  assign req_if.ld_rvalid_o    = ldRvalid_q;
  assign req_if.ld_rdata_o     = ds_rdata_i;

endmodule

// File: tb/tb_dcache_data_arbiter.sv
// Self-checking bench for dcache_data_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a line-level behavioural model of the data store and arbiter.
module tb_dcache_data_arbiter;

  localparam int DW       = 128;
  localparam int NW       = 256;
  localparam int BW       = 64;
  localparam int MAX_WAIT = 8;
  localparam int IW       = $clog2(NW);
  localparam int NB       = DW / 8;
  localparam int BB       = BW / 8;
  localparam int BEATS    = DW / BW;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_data_arbiter_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .BEAT_WIDTH(BW)) bus ();

  logic          dsEn, dsWe;
  logic [NB-1:0] dsBe;
  logic [IW-1:0] dsAddr;
  logic [DW-1:0] dsWdata, dsRdata;

  dcache_data_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .BEAT_WIDTH (BW),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_if     (bus),
    .ds_en_o    (dsEn),
    .ds_we_o    (dsWe),
    .ds_be_o    (dsBe),
    .ds_addr_o  (dsAddr),
    .ds_wdata_o (dsWdata),
    .ds_rdata_i (dsRdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Data store SRAM driven by the DUT: byte-enabled write, registered read.
  logic [DW-1:0] sram [NW];
  always @(posedge clk) begin
    if (dsEn) begin
      if (dsWe) begin
        for (int b = 0; b < NB; b++) if (dsBe[b]) sram[dsAddr][b*8 +: 8] <= dsWdata[b*8 +: 8];
      end else begin
        dsRdata <= sram[dsAddr];
      end
    end
  end

  // Reference model: line contents, refill progress, pending load result, consecutive load losses.
  logic [DW-1:0] mMem [NW];
  bit            mRefill = 1'b0;
  int            mBeat   = 0;
  logic [IW-1:0] mIdx    = '0;
  bit            mPend   = 1'b0;
  logic [DW-1:0] mPendData = '0;
  int            mWait   = 0;

  logic          eSt, eLd, eEn, eWe, eDone, eRvalid;
  logic [NB-1:0] eBe;
  logic [IW-1:0] eAddr;
  logic [DW-1:0] eWdata;

  always @(negedge clk) begin
    eSt = 0; eLd = 0; eEn = 0; eWe = 0; eDone = 0;
    eBe = '0; eAddr = '0; eWdata = '0;
    eRvalid = !rst && mPend;
    if (!rst) begin
      if (!mRefill) begin
        if (bus.refill_start_i) begin
          eSt = 0;
        end else if (bus.ld_req_i && GUARD && mWait >= MAX_WAIT) begin
          eLd = 1;
        end else if (bus.st_req_i) begin
          eSt = 1;
        end else if (bus.ld_req_i) begin
          eLd = 1;
        end
        if (eSt) begin
          eEn = 1; eWe = 1; eBe = bus.st_be_i; eAddr = bus.st_idx_i; eWdata = bus.st_wdata_i;
        end
        if (eLd) begin
          eEn = 1; eAddr = bus.ld_idx_i;
        end
      end else if (bus.refill_beat_valid_i) begin
        eEn = 1; eWe = 1; eAddr = mIdx;
        for (int b = 0; b < NB; b++) begin
          eBe[b] = ((b / BB) == mBeat);
          eWdata[b*8 +: 8] = bus.refill_beat_i[(b % BB)*8 +: 8];
        end
        eDone = (mBeat == BEATS - 1);
      end
    end

    checkOutput("st_gnt", bus.st_gnt_o, eSt);
    checkOutput("ld_gnt", bus.ld_gnt_o, eLd);
    checkOutput("refill_done", bus.refill_done_o, eDone);
    checkOutput("refill_ready", bus.refill_ready_o, 1'b1);
    checkOutput("ds_en", dsEn, eEn);
    checkOutput("ds_we", dsWe, eWe);
    checkOutput("ds_be", dsBe, eBe);
    checkOutput("ds_addr", dsAddr, eAddr);
    checkOutput("ds_wdata", dsWdata, eWdata);
    checkOutput("ld_rvalid", bus.ld_rvalid_o, eRvalid);
    if (eRvalid) checkOutput("ld_rdata", bus.ld_rdata_o, mPendData);

    if (rst) begin
      mRefill = 0; mBeat = 0; mPend = 0; mWait = 0;
    end else begin
      if (!bus.ld_req_i || eLd) mWait = 0;
      else if (!mRefill && mWait < MAX_WAIT) mWait++;
      mPend = eLd;
      if (eLd) mPendData = mMem[bus.ld_idx_i];
      if (eSt) begin
        for (int b = 0; b < NB; b++)
          if (bus.st_be_i[b]) mMem[bus.st_idx_i][b*8 +: 8] = bus.st_wdata_i[b*8 +: 8];
      end
      if (!mRefill && bus.refill_start_i) begin
        mRefill = 1; mIdx = bus.refill_idx_i; mBeat = 0;
      end else if (mRefill && bus.refill_beat_valid_i) begin
        for (int b = 0; b < BB; b++)
          mMem[mIdx][(mBeat*BB + b)*8 +: 8] = bus.refill_beat_i[b*8 +: 8];
        if (mBeat == BEATS - 1) begin
          mRefill = 0; mBeat = 0;
        end else begin
          mBeat++;
        end
      end
    end
  end

  int donePulses = 0;
  always @(negedge clk) if (bus.refill_done_o === 1'b1) donePulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.refill_start_i      = 0;
    bus.refill_idx_i        = '0;
    bus.refill_beat_valid_i = 0;
    bus.refill_beat_i       = '0;
    bus.st_req_i            = 0;
    bus.st_idx_i            = '0;
    bus.st_be_i             = '0;
    bus.st_wdata_i          = '0;
    bus.ld_req_i            = 0;
    bus.ld_idx_i            = '0;
  endtask

  task automatic applyStimulus();
    rst                     = ($urandom_range(63) == 0);
    bus.refill_start_i      = ($urandom_range(7) == 0);
    bus.refill_idx_i        = IW'($urandom_range(15));
    bus.refill_beat_valid_i = $urandom_range(1);
    bus.refill_beat_i       = {$urandom, $urandom};
    bus.st_req_i            = $urandom_range(1);
    bus.st_idx_i            = IW'($urandom_range(15));
    bus.st_be_i             = NB'($urandom);
    bus.st_wdata_i          = {$urandom, $urandom, $urandom, $urandom};
    bus.ld_req_i            = $urandom_range(1);
    bus.ld_idx_i            = IW'($urandom_range(15));
  endtask

  localparam logic [BW-1:0] RB0 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [BW-1:0] RB1 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [BW-1:0] XB0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [BW-1:0] XB1 = 64'hFEDC_BA98_7654_3210;

  int stCount, ldCount, expSt, expLd;

  initial begin
    logic [DW-1:0] v;
    rst = 1;
    clearInputs();
    for (int i = 0; i < NW; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      sram[i] = v;
      mMem[i] = v;
    end
    sram[5] = {16{8'hA5}}; mMem[5] = {16{8'hA5}};
    sram[3] = '0;          mMem[3] = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", bus.refill_ready_o, 1'b1);
    checkOutput("reset_ds_en", dsEn, 1'b0);
    checkOutput("reset_rvalid", bus.ld_rvalid_o, 1'b0);
    step();
    rst = 0;

    // Single load of a preloaded line.
    bus.ld_req_i = 1; bus.ld_idx_i = 5;
    @(negedge clk);
    checkOutput("load_gnt_c0", bus.ld_gnt_o, 1'b1);
    step();
    bus.ld_req_i = 0;
    @(negedge clk);
    checkOutput("load_rvalid_c1", bus.ld_rvalid_o, 1'b1);
    checkOutput("load_rdata_c1", bus.ld_rdata_o, {16{8'hA5}});

    // Store beats load to the same line; the load then sees the merged bytes.
    step();
    bus.st_req_i = 1; bus.st_idx_i = 3; bus.st_be_i = 16'h000F;
    bus.st_wdata_i = {96'hCAFE_F00D_1234_5678_9ABC_DEF0, 32'h1122_3344};
    bus.ld_req_i = 1; bus.ld_idx_i = 3;
    @(negedge clk);
    checkOutput("store_first_st", bus.st_gnt_o, 1'b1);
    checkOutput("store_first_ld", bus.ld_gnt_o, 1'b0);
    step();
    bus.st_req_i = 0;
    @(negedge clk);
    checkOutput("load_after_store_gnt", bus.ld_gnt_o, 1'b1);
    step();
    bus.ld_req_i = 0;
    @(negedge clk);
    checkOutput("load_after_store_data", bus.ld_rdata_o, 128'h1122_3344);

    // Refill with a two-cycle gap while a load waits.
    step();
    donePulses = 0;
    bus.refill_start_i = 1; bus.refill_idx_i = 7;
    bus.ld_req_i = 1; bus.ld_idx_i = 7;
    @(negedge clk);
    checkOutput("start_blocks_load", bus.ld_gnt_o, 1'b0);
    step();
    bus.refill_start_i = 0; bus.refill_beat_valid_i = 1; bus.refill_beat_i = RB0;
    step();
    bus.refill_beat_valid_i = 0;
    @(negedge clk);
    checkOutput("gap_blocks_load", bus.ld_gnt_o, 1'b0);
    step();
    step();
    bus.refill_beat_valid_i = 1; bus.refill_beat_i = RB1;
    @(negedge clk);
    checkOutput("last_beat_done", bus.refill_done_o, 1'b1);
    step();
    bus.refill_beat_valid_i = 0;
    @(negedge clk);
    checkOutput("load_after_done", bus.ld_gnt_o, 1'b1);
    step();
    bus.ld_req_i = 0;
    @(negedge clk);
    checkOutput("refill_line", bus.ld_rdata_o, {RB1, RB0});
    checkOutput("done_pulses", donePulses, 1);

    // Reset in the middle of a burst, then a clean refill of the same line.
    step();
    bus.refill_start_i = 1; bus.refill_idx_i = 9;
    step();
    bus.refill_start_i = 0; bus.refill_beat_valid_i = 1; bus.refill_beat_i = 64'h1111_2222_3333_4444;
    step();
    rst = 1; bus.refill_beat_valid_i = 0;
    @(negedge clk);
    checkOutput("midburst_rst_ready", bus.refill_ready_o, 1'b1);
    checkOutput("midburst_rst_en", dsEn, 1'b0);
    step();
    rst = 0; bus.refill_beat_valid_i = 1; bus.refill_beat_i = 64'h9999_9999_9999_9999;
    @(negedge clk);
    checkOutput("idle_beat_ignored", dsEn, 1'b0);
    step();
    bus.refill_beat_valid_i = 0; bus.refill_start_i = 1; bus.refill_idx_i = 9;
    step();
    bus.refill_start_i = 0; bus.refill_beat_valid_i = 1; bus.refill_beat_i = XB0;
    step();
    bus.refill_beat_i = XB1;
    @(negedge clk);
    checkOutput("clean_refill_done", bus.refill_done_o, 1'b1);
    step();
    bus.refill_beat_valid_i = 0; bus.ld_req_i = 1; bus.ld_idx_i = 9;
    step();
    bus.ld_req_i = 0;
    @(negedge clk);
    checkOutput("clean_refill_line", bus.ld_rdata_o, {XB1, XB0});

    // Store and load both held: fixed priority, or one load per MAX_WAIT stores with the guard.
    step();
    bus.st_req_i = 1; bus.st_idx_i = 20; bus.st_be_i = 16'hFFFF; bus.st_wdata_i = {4{32'h5A5A_0F0F}};
    bus.ld_req_i = 1; bus.ld_idx_i = 21;
    stCount = 0; ldCount = 0;
    repeat (2 * (MAX_WAIT + 1)) begin
      @(negedge clk);
      if (bus.st_gnt_o === 1'b1) stCount++;
      if (bus.ld_gnt_o === 1'b1) ldCount++;
      step();
    end
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    expSt = 2 * MAX_WAIT; expLd = 2;
`else
    expSt = 2 * (MAX_WAIT + 1); expLd = 0;
`endif
    checkOutput("starve_store_grants", stCount, expSt);
    checkOutput("starve_load_grants", ldCount, expLd);
    clearInputs();

    // Randomized traffic, including occasional resets.
    repeat (600) begin
      applyStimulus();
      step();
    end
    rst = 0;
    clearInputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
